fp_stream_reduce: RTL and testbench
===================================

// Module: fp_stream_reduce
// PURPOSE
//  Streaming reduction over packets of NCH-wide IEEE754 vectors (fields per `IEEE754(NX, NM)).
//  Each beat's channels fold through a compare tree; beats fold into a running accumulator.
//  Emits one scalar result (MAX, MIN or ABSMAX) and a beat count per packet.
//  Sits between vector datapaths and the stats/normalisation logic, on valid/ready streams.
// PARAMETERS
//  NX    8   exponent width
//  NM    23  mantissa width; element width W = 1+NX+NM
//  NCH   4   channels per beat, power of two, >=1
//  CNTW  16  beat-counter width
// PORTS
//  CLK        in   1        clock, rising edge
//  RST        in   1        synchronous, active-high reset
//  OP         in   2        0=MAX 1=MIN 2=ABSMAX 3=reserved (treated as MAX); sampled on first beat
//  IN_VALID   in   1        input beat valid
//  IN_READY   out  1        input beat accepted when IN_VALID&IN_READY
//  IN_DATA    in   NCH*W    channel k at [k*W +: W]
//  IN_LAST    in   1        final beat of packet
//  OUT_VALID  out  1        result valid; held until OUT_READY
//  OUT_READY  in   1        downstream accept
//  OUT_DATA   out  W        reduced value
//  OUT_COUNT  out  CNTW     beats in packet, saturating at 2**CNTW-1
//  OUT_NAN    out  1        packet contained NaN (only with FP_REDUCE_NAN_EN, else tied 0)
// BEHAVIOUR
//  Reset: OUT_VALID=0, OUT_DATA=0, OUT_COUNT=0, OUT_NAN=0, IN_READY=1 next cycle; state IDLE.
//  Compare: sign-magnitude order on packed bits; +0 > -0; ABSMAX compares with sign cleared,
//   returns the original operand (sign kept). Ties keep lower channel / earlier beat.
//  Stage 1 (reg): NCH-input tree reduce, log2(NCH) levels combinational, plus last flag.
//  Stage 2 (reg): accumulator; first beat loads, later beats compare-and-keep.
//  FSM: IDLE -(beat accepted)-> ACCUM; ACCUM -(stage1 last folds)-> HOLD;
//   HOLD -(OUT_VALID&OUT_READY)-> IDLE. A one-beat packet goes IDLE->HOLD.
//  Latency: OUT_VALID rises 2 cycles after the IN_LAST beat is accepted.
//  IN_READY = (state!=HOLD) && !(s1_valid && s1_last); no beat of the next packet enters
//   until the result handshake completes. Next-packet beat accepted in the cycle after
//   OUT handshake (IN_READY rises combinationally off the registered state).
//  OP latched with first beat; OP changes mid-packet ignored.
//  Count increments per accepted beat, saturates; reloads 1 on next packet's first beat.
//  RST mid-packet: accumulator, stage 1 and count discarded, no partial result emitted.
//  Denormals compared as encoded; no flushing.
// CONFIGURATION
//  FP_REDUCE_NAN_EN defined: NaN (exp all ones, mant!=0) on any channel sets sticky packet
//   flag; result forced to canonical qNaN {0, all-ones exp, 1'b1, zeros}; OUT_NAN=1.
//  Undefined: NaN bit patterns ordered like any other value; OUT_NAN tied 0; no flag logic.
// STRUCTURE
//  Package fp: MAX/MIN lets, EXP_OFFSET; add fp_gt(a,b) ordered compare, IS_NAN(NX,NM),
//   QNAN(NX,NM) constant function, op_e enum {OP_MAX, OP_MIN, OP_ABSMAX}.
//  Element type via `IEEE754(NX, NM) macro.
//  Sub-module fp_cmp_sel: two-operand compare/select per op (+ NaN OR when enabled);
//   instantiated NCH-1 times in the tree and once in the accumulator.
// TESTING  (NX=8, NM=23, NCH=4)
//  1 beat MAX {3F800000,40000000,C0400000,3F000000} last -> 40000000, count 1, 2 cycles later.
//  Same beat, ABSMAX -> C0400000; MIN -> C0400000.
//  3-beat MIN packet, OUT_READY low 5 cycles -> OUT held stable, IN_READY=0 throughout;
//   next packet accepted the cycle after handshake; count 3.
//  MAX over {80000000 x4} then {00000000 x4} -> 00000000; OP switched mid-packet -> ignored.
//  RST asserted after 2 beats of a packet -> no OUT_VALID; following 1-beat packet count 1.
//  NAN_EN: channel 7FC00001 in beat 2 of 3 -> OUT_DATA 7FC00000, OUT_NAN=1; without
//   macro -> OUT_DATA 7FC00001 (MAX), OUT_NAN=0.

Source files
------------

// File: rtl/fp_stream_reduce_pkg.sv
// Shared element macro, op encoding and ordered-compare helper for fp_stream_reduce.
`ifndef IEEE754
`define IEEE754(NX, NM) struct packed { logic sign; logic [(NX)-1:0] exp; logic [(NM)-1:0] mant; }
`endif

package fp_stream_reduce_pkg;

  typedef enum logic [1:0] {
    OP_MAX    = 2'd0,
    OP_MIN    = 2'd1,
    OP_ABSMAX = 2'd2
  } op_e;

  // Reserved encoding falls back to MAX.
  function automatic op_e op_decode(input logic [1:0] raw);
    case (raw)
      2'd1:    return OP_MIN;
      2'd2:    return OP_ABSMAX;
      default: return OP_MAX;
    endcase
  endfunction

  // x > y in sign-magnitude order, given the magnitude relation; +0 beats -0.
  function automatic logic fp_gt(input logic sign_x, input logic sign_y,
                                 input logic mag_gt, input logic mag_lt);
    case ({sign_x, sign_y})
      2'b01:   return 1'b1;
      2'b10:   return 1'b0;
      2'b00:   return mag_gt;
      default: return mag_lt;
    endcase
  endfunction

endpackage

// File: rtl/fp_stream_reduce_cmp_sel.sv
// Two-operand compare/select; a wins ties. NaN flag OR only with FP_REDUCE_NAN_EN.
module fp_stream_reduce_cmp_sel
  import fp_stream_reduce_pkg::*;
#(
  parameter int unsigned NX = 8,
  parameter int unsigned NM = 23
) (
  input  op_e              op_i,
  input  logic [NX+NM:0]   a_i,
  input  logic [NX+NM:0]   b_i,
  input  logic             nan_a_i,
  input  logic             nan_b_i,
  output logic [NX+NM:0]   y_c_o,
  output logic             nan_c_o
);

  logic              sign_a, sign_b;
  logic [NX+NM-1:0]  mag_a, mag_b;
  logic              take_b;

  assign {sign_a, mag_a} = a_i;
  assign {sign_b, mag_b} = b_i;

  always_comb begin
    take_b = 1'b0;
    case (op_i)
      OP_MIN:    take_b = fp_gt(sign_a, sign_b, mag_a > mag_b, mag_a < mag_b);
      OP_ABSMAX: take_b = mag_b > mag_a;
      default:   take_b = fp_gt(sign_b, sign_a, mag_b > mag_a, mag_b < mag_a);
    endcase
  end

  assign y_c_o = take_b ? b_i : a_i;

`ifdef FP_REDUCE_NAN_EN
  assign nan_c_o = nan_a_i | nan_b_i;
`else
  logic unused_nan;
  assign unused_nan = nan_a_i ^ nan_b_i;
  assign nan_c_o    = 1'b0;
`endif

endmodule

// File: rtl/fp_stream_reduce.sv
// Per-packet MAX/MIN/ABSMAX reduction over NCH-wide float beats with beat count.
// Optional NaN tracking and canonical-qNaN forcing under FP_REDUCE_NAN_EN.
module fp_stream_reduce
  import fp_stream_reduce_pkg::*;
#(
  parameter  int unsigned NX   = 8,
  parameter  int unsigned NM   = 23,
  parameter  int unsigned NCH  = 4,
  parameter  int unsigned CNTW = 16,
  localparam int unsigned W    = 1 + NX + NM
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       op_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [NCH*W-1:0] in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [W-1:0]     out_data_o,
  output logic [CNTW-1:0]  out_count_o,
  output logic             out_nan_o
);

  localparam int unsigned LG   = $clog2(NCH);
  localparam logic [W-1:0] QNAN = {1'b0, {NX{1'b1}}, 1'b1, {(NM-1){1'b0}}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  typedef `IEEE754(NX, NM) elem_t;

  logic [1:0]      state_q, state_d;
  logic            in_pkt_q, in_pkt_d;
  op_e             op_q, op_d, op_eff;
  logic            s1_valid_q, s1_valid_d, s1_last_q, s1_last_d, s1_nan_q, s1_nan_d;
  logic [W-1:0]    s1_data_q, s1_data_d;
  logic [W-1:0]    acc_q, acc_d;
  logic            acc_nan_q, acc_nan_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            out_valid_q, out_valid_d;
  logic            accept;
  logic [W-1:0]    tree_data, fold_data;
  logic            tree_nan, fold_nan;

  assign in_ready_o = (state_q != S_HOLD) && !(s1_valid_q && s1_last_q);
  assign accept     = in_valid_i && in_ready_o;
  // The first beat of a packet is folded with the live op before it is latched.
  assign op_eff     = in_pkt_q ? op_q : op_decode(op_i);

  for (genvar l = 0; l <= LG; l++) begin : g_lvl
    logic [W-1:0] v [NCH>>l];
    logic         n [NCH>>l];
    if (l == 0) begin : g_leaf
      for (genvar j = 0; j < NCH; j++) begin : g_ch
        elem_t e;
        assign e    = elem_t'(in_data_i[j*W +: W]);
        assign v[j] = e;
`ifdef FP_REDUCE_NAN_EN
        assign n[j] = (e.exp == {NX{1'b1}}) && (e.mant != '0);
`else
        assign n[j] = 1'b0;
`endif
      end
    end else begin : g_fold
      for (genvar j = 0; j < (NCH >> l); j++) begin : g_pair
        fp_stream_reduce_cmp_sel #(.NX(NX), .NM(NM)) u_sel (
          .op_i    (op_eff),
          .a_i     (g_lvl[l-1].v[2*j]),
          .b_i     (g_lvl[l-1].v[2*j+1]),
          .nan_a_i (g_lvl[l-1].n[2*j]),
          .nan_b_i (g_lvl[l-1].n[2*j+1]),
          .y_c_o   (v[j]),
          .nan_c_o (n[j])
        );
      end
    end
  end

  assign tree_data = g_lvl[LG].v[0];
  assign tree_nan  = g_lvl[LG].n[0];

  fp_stream_reduce_cmp_sel #(.NX(NX), .NM(NM)) u_acc_sel (
    .op_i    (op_q),
    .a_i     (acc_q),
    .b_i     (s1_data_q),
    .nan_a_i (acc_nan_q),
    .nan_b_i (s1_nan_q),
    .y_c_o   (fold_data),
    .nan_c_o (fold_nan)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      in_pkt_q    <= 1'b0;
      op_q        <= OP_MAX;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_nan_q    <= 1'b0;
      s1_data_q   <= '0;
      acc_q       <= '0;
      acc_nan_q   <= 1'b0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_pkt_q    <= in_pkt_d;
      op_q        <= op_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_nan_q    <= s1_nan_d;
      s1_data_q   <= s1_data_d;
      acc_q       <= acc_d;
      acc_nan_q   <= acc_nan_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    in_pkt_d   = in_pkt_q;
    op_d       = op_q;
    s1_valid_d = accept;
    s1_last_d  = s1_last_q;
    s1_nan_d   = s1_nan_q;
    s1_data_d  = s1_data_q;
    acc_d      = acc_q;
    acc_nan_d  = acc_nan_q;
    count_d    = count_q;

    if (accept) begin
      s1_data_d = tree_data;
      s1_nan_d  = tree_nan;
      s1_last_d = in_last_i;
      in_pkt_d  = !in_last_i;
      if (!in_pkt_q) op_d = op_decode(op_i);
    end

    // State tracks the accumulator: IDLE means it holds no beat of the current packet.
    case (state_q)
      S_IDLE: begin
        if (s1_valid_q) begin
          acc_d     = s1_nan_q ? QNAN : s1_data_q;
          acc_nan_d = s1_nan_q;
          count_d   = CNTW'(1);
          state_d   = s1_last_q ? S_HOLD : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (s1_valid_q) begin
          acc_d     = fold_nan ? QNAN : fold_data;
          acc_nan_d = fold_nan;
          count_d   = (count_q == {CNTW{1'b1}}) ? count_q : count_q + CNTW'(1);
          if (s1_last_q) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    out_valid_d = (state_d == S_HOLD);
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = acc_q;
  assign out_count_o = count_q;
  assign out_nan_o   = acc_nan_q;

endmodule

// File: tb/tb_fp_stream_reduce.sv
// Scoreboard bench for fp_stream_reduce (NX=8, NM=23, NCH=4, CNTW=16).
module tb_fp_stream_reduce;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   op;
  logic         in_valid, in_ready, in_last;
  logic [127:0] in_data;
  logic         out_valid, out_ready, out_nan;
  logic [31:0]  out_data;
  logic [15:0]  out_count;

  typedef struct {
    logic [31:0] data;
    logic [15:0] count;
    logic        nan;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   last_wait = 0;

  always #5 clk = ~clk;

  fp_stream_reduce #(.NX(8), .NM(23), .NCH(4), .CNTW(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .op_i        (op),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_last_i   (in_last),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_count_o (out_count),
    .out_nan_o   (out_nan)
  );

  // Monitor: every cycle a result is presented it must equal the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got data=%h count=%0d nan=%b, required no result",
                 out_data, out_count, out_nan);
      end else begin
        if (out_data !== exp_q[0].data || out_count !== exp_q[0].count ||
            out_nan !== exp_q[0].nan) begin
          errors++;
          $display("FAIL result: got data=%h count=%0d nan=%b, required data=%h count=%0d nan=%b",
                   out_data, out_count, out_nan, exp_q[0].data, exp_q[0].count, exp_q[0].nan);
        end
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  function automatic logic [127:0] pack(input logic [31:0] c0, input logic [31:0] c1,
                                        input logic [31:0] c2, input logic [31:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic expect_res(input logic [31:0] d, input logic [15:0] c, input logic n);
    exp_t e;
    e.data = d; e.count = c; e.nan = n;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [127:0] d, input logic last, input logic [1:0] o);
    int   waits;
    logic rdy;
    waits    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    op       = o;
    rdy      = in_ready;
    while (!rdy && waits < 200) begin
      step();
      waits++;
      rdy = in_ready;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no acceptance after %0d cycles, required acceptance", waits);
    end else begin
      step();
    end
    last_wait = waits;
    in_valid  = 1'b0;
    in_last   = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      step();
      g++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  logic [127:0] vd [9];
  logic [1:0]   vo [9];
  logic [31:0]  ve [9];
  logic [127:0] bt;

  initial begin
    rst = 1'b1; op = 2'd0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  out_data,       32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_out_nan",   32'(out_nan),   32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // One-beat MAX with latency check.
    bt = pack(32'h3F800000, 32'h40000000, 32'hC0400000, 32'h3F000000);
    expect_res(32'h40000000, 16'd1, 1'b0);
    send(bt, 1'b1, 2'd0);
    chk("lat_cycle1_valid", 32'(out_valid), 32'd0);
    step();
    chk("lat_cycle2_valid", 32'(out_valid), 32'd1);

    // One-beat table: ops, reserved op, ties, signed zeros, denormals.
    vd[0] = bt; vo[0] = 2'd2; ve[0] = 32'hC0400000;
    vd[1] = bt; vo[1] = 2'd1; ve[1] = 32'hC0400000;
    vd[2] = bt; vo[2] = 2'd3; ve[2] = 32'h40000000;
    vd[3] = pack(32'h3F800000, 32'hBF800000, 32'h3F000000, 32'h00000000); vo[3] = 2'd2; ve[3] = 32'h3F800000;
    vd[4] = pack(32'h80000000, 32'h00000000, 32'h80000000, 32'h00000000); vo[4] = 2'd0; ve[4] = 32'h00000000;
    vd[5] = pack(32'h00000000, 32'h80000000, 32'h00000000, 32'h80000000); vo[5] = 2'd1; ve[5] = 32'h80000000;
    vd[6] = pack(32'h00000001, 32'h80000002, 32'h00000000, 32'h80000000); vo[6] = 2'd2; ve[6] = 32'h80000002;
    vd[7] = pack(32'h00000001, 32'h80000002, 32'h00000000, 32'h80000000); vo[7] = 2'd0; ve[7] = 32'h00000001;
    vd[8] = pack(32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000); vo[8] = 2'd1; ve[8] = 32'hBF800000;
    for (int i = 0; i < 9; i++) begin
      expect_res(ve[i], 16'd1, 1'b0);
      send(vd[i], 1'b1, vo[i]);
    end
    drain();

    // Earlier beat wins an ABSMAX tie across beats.
    expect_res(32'hBF800000, 16'd2, 1'b0);
    send(pack(32'hBF800000, 32'h0, 32'h0, 32'h0), 1'b0, 2'd2);
    send(pack(32'h3F800000, 32'h0, 32'h0, 32'h0), 1'b1, 2'd2);
    drain();

    // Three-beat MIN under backpressure.
    out_ready = 1'b0;
    expect_res(32'hC0000000, 16'd3, 1'b0);
    send(pack(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000), 1'b0, 2'd1);
    send(pack(32'hBF800000, 32'h3F000000, 32'h40A00000, 32'h3F800000), 1'b0, 2'd0);
    send(pack(32'hC0000000, 32'h80000000, 32'h00000000, 32'h3F800000), 1'b1, 2'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      step();
    end
    chk("bp_out_valid_held", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    chk("bp_in_ready_at_handshake", 32'(in_ready), 32'd0);
    step();
    chk("bp_in_ready_after_handshake", 32'(in_ready), 32'd1);
    expect_res(32'h3F800000, 16'd1, 1'b0);
    send(pack(32'h3F800000, 32'h0, 32'h0, 32'h0), 1'b1, 2'd0);
    chk("bp_next_accept_wait", 32'(last_wait), 32'd0);
    drain();

    // Mid-packet op change ignored (accumulator and tree).
    expect_res(32'h00000000, 16'd2, 1'b0);
    send(pack(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000), 1'b0, 2'd0);
    send(pack(32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000), 1'b1, 2'd1);
    expect_res(32'h3F800000, 16'd2, 1'b0);
    send(pack(32'hBF800000, 32'hBF800000, 32'hBF800000, 32'hBF800000), 1'b0, 2'd0);
    send(pack(32'h00000000, 32'h3F800000, 32'hBF800000, 32'h80000000), 1'b1, 2'd1);
    drain();

    // Reset mid-packet discards the partial result.
    send(pack(32'h7F000000, 32'h0, 32'h0, 32'h0), 1'b0, 2'd0);
    send(pack(32'h7F000000, 32'h0, 32'h0, 32'h0), 1'b0, 2'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count",     32'(out_count), 32'd0);
    chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
    for (int i = 0; i < 3; i++) step();
    expect_res(32'h3F800000, 16'd1, 1'b0);
    send(pack(32'h3F800000, 32'h0, 32'h0, 32'h0), 1'b1, 2'd0);
    drain();

    // NaN in beat 2 of 3, then a clean packet.
`ifdef FP_REDUCE_NAN_EN
    expect_res(32'h7FC00000, 16'd3, 1'b1);
`else
    expect_res(32'h7FC00001, 16'd3, 1'b0);
`endif
    send(pack(32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3F800000), 1'b0, 2'd0);
    send(pack(32'h7FC00001, 32'h3F800000, 32'hBF800000, 32'h00000000), 1'b0, 2'd0);
    send(pack(32'h40400000, 32'h00000000, 32'h00000000, 32'h00000000), 1'b1, 2'd0);
    expect_res(32'h40400000, 16'd1, 1'b0);
    send(pack(32'h40400000, 32'h3F800000, 32'h00000000, 32'h00000000), 1'b1, 2'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
